// File: rtl/scalar_pkg.sv
// rtl/scalar_pkg.sv - shared state encoding, default sizes and width helper for the scalar-product feeder
package scalar_pkg;

  localparam int NBITS = 4;
  localparam int NDATA = 4;
  localparam int NMAC  = 2;
  localparam int NLAT  = NDATA / NMAC + 1;
  localparam int VEC_W = NDATA * NBITS;
  localparam int RES_W = 2 * NBITS;

  // Index registers need at least one bit even when only one value exists
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int IDX_W = idx_width(NDATA);
  localparam int CNT_W = idx_width(NLAT);

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_RUN   = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/scalar_operand_packer.sv
// rtl/scalar_operand_packer.sv - indexed write of one (a,b) element pair into the flat operand registers
module scalar_operand_packer
  import scalar_pkg::*;
#(
  parameter int Nbits = NBITS,
  parameter int Ndata = NDATA,
  parameter int IW    = idx_width(NDATA)
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   wr_en,
  input  logic [IW-1:0]          wr_idx,
  input  logic [Nbits-1:0]       a,
  input  logic [Nbits-1:0]       b,
  output logic [Ndata*Nbits-1:0] a_vec,
  output logic [Ndata*Nbits-1:0] b_vec
);

  // Slots not addressed by this write keep the previous vector's element
  always_ff @(posedge clk) begin
    if (!resetn) begin
      a_vec <= '0;
      b_vec <= '0;
    end else if (wr_en) begin
      for (int k = 0; k < Ndata; k++) begin
        if (wr_idx == IW'(k)) begin
          a_vec[k*Nbits +: Nbits] <= a;
          b_vec[k*Nbits +: Nbits] <= b;
        end
      end
    end
  end

endmodule

// File: rtl/scalar_product_feeder.sv
// rtl/scalar_product_feeder.sv - gathers operand pairs, sequences the MAC array clear/compute window and returns the dot product
module scalar_product_feeder
  import scalar_pkg::*;
#(
  parameter int Nbits = NBITS,
  parameter int Ndata = NDATA,
  parameter int Nmac  = NMAC,
  parameter int Nlat  = Ndata / Nmac + 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [Nbits-1:0]       in_a,
  input  logic [Nbits-1:0]       in_b,
  output logic [Ndata*Nbits-1:0] A_out,
  output logic [Ndata*Nbits-1:0] B_out,
  output logic                   mac_clr,
  input  logic [2*Nbits-1:0]     mac_out,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [2*Nbits-1:0]     res_data
);

  localparam int IW = idx_width(Ndata);
  localparam int CW = idx_width(Nlat);

  state_t         state;
  state_t         state_nxt;
  logic [IW-1:0]  idx;
  logic [CW-1:0]  cnt;
  logic           accept;
  logic           last_slot;
  logic           run_done;

  assign accept    = in_valid && in_ready;
  assign last_slot = (idx == IW'(Ndata - 1));
  assign run_done  = (cnt == CW'(Nlat - 1));

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= ST_LOAD;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = ST_LOAD;
    case (state)
      ST_LOAD:  state_nxt = (accept && last_slot) ? ST_CLEAR : ST_LOAD;
      ST_CLEAR: state_nxt = ST_RUN;
      ST_RUN:   state_nxt = run_done ? ST_DONE : ST_RUN;
      ST_DONE:  state_nxt = res_ready ? ST_LOAD : ST_DONE;
      default:  state_nxt = ST_LOAD;
    endcase
  end

  // Gated by reset so neither a load nor a clear escapes while reset is held
  always_comb begin
    in_ready = 1'b0;
    mac_clr  = 1'b0;
    case (state)
      ST_LOAD:  in_ready = reset;
      ST_CLEAR: mac_clr  = reset;
      default: begin
        in_ready = 1'b0;
        mac_clr  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      idx       <= '0;
      cnt       <= '0;
      res_data  <= '0;
      res_valid <= 1'b0;
    end else begin
      case (state)
        ST_LOAD: begin
          if (accept) begin
            idx <= last_slot ? '0 : idx + IW'(1);
          end
        end
        ST_CLEAR: cnt <= '0;
        ST_RUN: begin
          cnt <= cnt + CW'(1);
          // Last compute cycle: the array output is settled, capture it
          if (run_done) begin
            res_data  <= mac_out;
            res_valid <= 1'b1;
          end
        end
        ST_DONE: begin
          if (res_ready) begin
            res_valid <= 1'b0;
          end
        end
        default: begin
          idx       <= '0;
          cnt       <= '0;
          res_valid <= 1'b0;
        end
      endcase
    end
  end

  scalar_operand_packer #(
    .Nbits (Nbits),
    .Ndata (Ndata),
    .IW    (IW)
  ) u_packer (
    .clk    (clk),
    .resetn (reset),
    .wr_en  (accept),
    .wr_idx (idx),
    .a      (in_a),
    .b      (in_b),
    .a_vec  (A_out),
    .b_vec  (B_out)
  );

endmodule

// File: tb/tb_scalar_product_feeder.sv
// tb/tb_scalar_product_feeder.sv - directed and randomized self-checking bench for scalar_product_feeder
module tb_scalar_product_feeder;

  localparam int NB = 4;
  localparam int ND = 4;
  localparam int NL = 3;

  logic              clk = 1'b0;
  logic              reset;
  logic              in_valid;
  logic              in_ready;
  logic [NB-1:0]     in_a;
  logic [NB-1:0]     in_b;
  logic [ND*NB-1:0]  A_out;
  logic [ND*NB-1:0]  B_out;
  logic              mac_clr;
  logic [2*NB-1:0]   mac_out;
  logic              res_valid;
  logic              res_ready;
  logic [2*NB-1:0]   res_data;

  int n_cmp  = 0;
  int n_fail = 0;
  int clr_cnt = 0;
  int acc_cnt = 0;
  int exp_clr = 0;
  int exp_acc = 0;

  logic [NB-1:0] va [ND];
  logic [NB-1:0] vb [ND];

  scalar_product_feeder #(.Nbits(NB), .Ndata(ND), .Nmac(2), .Nlat(NL)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .A_out     (A_out),
    .B_out     (B_out),
    .mac_clr   (mac_clr),
    .mac_out   (mac_out),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data)
  );

  always #5 clk = ~clk;

  // External MAC array: output only correct from the last compute cycle after a clear
  logic [3:0]      since_clr = 4'hF;
  logic [2*NB-1:0] arr_dot;
  always_comb begin
    arr_dot = '0;
    for (int k = 0; k < ND; k++) arr_dot += (2*NB)'(A_out[k*NB +: NB]) * (2*NB)'(B_out[k*NB +: NB]);
  end
  assign mac_out = (since_clr >= 4'(NL - 1)) ? arr_dot : (arr_dot ^ 8'hA5);

  always @(posedge clk) begin
    if (mac_clr) since_clr <= 4'd0;
    else if (since_clr != 4'hF) since_clr <= since_clr + 4'd1;
    if (mac_clr) clr_cnt <= clr_cnt + 1;
    if (reset && in_valid && in_ready) acc_cnt <= acc_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2*NB-1:0] model_dot();
    int s = 0;
    for (int i = 0; i < ND; i++) s += int'(va[i]) * int'(vb[i]);
    return s[2*NB-1:0];
  endfunction

  function automatic logic [ND*NB-1:0] model_pack(input bit use_b);
    logic [ND*NB-1:0] p = '0;
    for (int i = 0; i < ND; i++) p |= (ND*NB)'(use_b ? vb[i] : va[i]) << (NB * i);
    return p;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_pairs(input int gap, input bit keep_valid);
    for (int i = 0; i < ND; i++) begin
      int budget = 0;
      in_a = va[i];
      in_b = vb[i];
      in_valid = 1'b1;
      while (!in_ready && budget < 20) begin
        step();
        budget++;
      end
      chk("in_ready_wait", 32'(in_ready), 32'd1);
      step();
      exp_acc++;
      if (i == 1 && gap > 0) begin
        in_valid = 1'b0;
        for (int g = 0; g < gap; g++) begin
          chk("gap_in_ready", 32'(in_ready), 32'd1);
          chk("gap_mac_clr", 32'(mac_clr), 32'd0);
          step();
        end
      end
    end
    if (!keep_valid) in_valid = 1'b0;
  endtask

  // Entered in the cycle after the last accepted pair
  task automatic check_run(input int hold, input bit tie);
    logic [2*NB-1:0]  exp_res = model_dot();
    logic [ND*NB-1:0] exp_a = model_pack(1'b0);
    logic [ND*NB-1:0] exp_b = model_pack(1'b1);
    exp_clr++;
    for (int k = 1; k <= NL + 1; k++) begin
      chk("run_mac_clr", 32'(mac_clr), 32'(k == 1));
      chk("run_res_valid", 32'(res_valid), 32'd0);
      chk("run_in_ready", 32'(in_ready), 32'd0);
      chk("run_A_out", 32'(A_out), 32'(exp_a));
      chk("run_B_out", 32'(B_out), 32'(exp_b));
      step();
    end
    chk("res_valid_rise", 32'(res_valid), 32'd1);
    chk("res_data", 32'(res_data), 32'(exp_res));
    if (!tie) res_ready = 1'b0;
    for (int h = 0; h < hold; h++) begin
      step();
      chk("hold_res_valid", 32'(res_valid), 32'd1);
      chk("hold_res_data", 32'(res_data), 32'(exp_res));
      chk("hold_in_ready", 32'(in_ready), 32'd0);
    end
    res_ready = 1'b1;
    step();
    chk("hs_res_valid", 32'(res_valid), 32'd0);
    chk("hs_in_ready", 32'(in_ready), 32'd1);
    if (!tie) res_ready = 1'b0;
  endtask

  task automatic rand_vec();
    for (int i = 0; i < ND; i++) begin
      va[i] = NB'($urandom_range(0, 15));
      vb[i] = NB'($urandom_range(0, 15));
    end
  endtask

  task automatic const_vec(input int a0, input int a1, input int a2, input int a3, input int b);
    va[0] = NB'(a0); va[1] = NB'(a1); va[2] = NB'(a2); va[3] = NB'(a3);
    for (int i = 0; i < ND; i++) vb[i] = NB'(b);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; res_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_A_out", 32'(A_out), 32'd0);
    chk("rst_B_out", 32'(B_out), 32'd0);
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_res_data", 32'(res_data), 32'd0);
    chk("rst_mac_clr", 32'(mac_clr), 32'd0);
    reset = 1'b1;
    step();
    chk("rel_in_ready", 32'(in_ready), 32'd1);

    // Basic
    const_vec(1, 2, 3, 4, 1);
    send_pairs(0, 1'b0);
    chk("basic_A_out", 32'(A_out), 32'h4321);
    chk("basic_model", 32'(model_dot()), 32'd10);
    check_run(0, 1'b0);

    // Overflow wraps
    const_vec(15, 15, 15, 15, 15);
    send_pairs(0, 1'b0);
    chk("ovf_model", 32'(model_dot()), 32'h84);
    check_run(0, 1'b0);

    // Input gap after pair 1
    rand_vec();
    send_pairs(3, 1'b0);
    check_run(0, 1'b0);

    // Result backpressure
    rand_vec();
    send_pairs(0, 1'b0);
    check_run(5, 1'b0);

    // Reset while cnt==1 in RUN
    rand_vec();
    send_pairs(0, 1'b0);
    exp_clr++;
    step();
    step();
    reset = 1'b0;
    step();
    chk("mid_A_out", 32'(A_out), 32'd0);
    chk("mid_B_out", 32'(B_out), 32'd0);
    chk("mid_res_valid", 32'(res_valid), 32'd0);
    chk("mid_res_data", 32'(res_data), 32'd0);
    chk("mid_mac_clr", 32'(mac_clr), 32'd0);
    chk("mid_in_ready", 32'(in_ready), 32'd0);
    reset = 1'b1;
    step();
    chk("mid_rel_in_ready", 32'(in_ready), 32'd1);
    for (int c = 0; c < 3; c++) begin
      step();
      chk("mid_idle_res_valid", 32'(res_valid), 32'd0);
      chk("mid_idle_mac_clr", 32'(mac_clr), 32'd0);
    end
    const_vec(2, 2, 2, 2, 3);
    send_pairs(0, 1'b0);
    check_run(0, 1'b0);

    // Back-to-back with res_ready tied high and in_valid left asserted
    res_ready = 1'b1;
    const_vec(1, 2, 3, 4, 1);
    send_pairs(0, 1'b1);
    check_run(0, 1'b1);
    const_vec(2, 2, 2, 2, 3);
    send_pairs(0, 1'b1);
    check_run(0, 1'b1);
    in_valid = 1'b0;
    res_ready = 1'b0;

    // Random vectors with random gaps and hold times
    for (int r = 0; r < 6; r++) begin
      rand_vec();
      send_pairs(int'($urandom_range(0, 2)), 1'b0);
      check_run(int'($urandom_range(0, 3)), 1'b0);
    end

    step();
    chk("clr_pulses", 32'(clr_cnt), 32'(exp_clr));
    chk("accepts", 32'(acc_cnt), 32'(exp_acc));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
